// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults, counter width and total-length helpers for the video timing generator.
// Pure constants and functions, no logic.
package video_timing_pkg;

    localparam int CNT_W   = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 224;
    localparam int DEF_V_FP     = 16;
    localparam int DEF_V_SYNC   = 8;
    localparam int DEF_V_BP     = 16;
    localparam int DEF_CE_DIV   = 4;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_ce_div.sv
// Pixel clock-enable divider: oTICK is high while the phase counter sits at CE_DIV-1 (combinational).
// Free running, no backpressure; CE_DIV = 1 gives a permanently high tick.
module video_ce_div #(
    parameter int CE_DIV = 4
) (
    input  logic iPCLK,
    input  logic iRSTn,
    output logic oTICK
);

    localparam logic [3:0] D_LAST = 4'(CE_DIV - 1);

    logic [3:0] d_q;
    logic [3:0] d_d;

    assign oTICK = (d_q == D_LAST);

    always_comb begin
        d_d = oTICK ? 4'd0 : d_q + 4'd1;
    end

    always_ff @(posedge iPCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            d_q <= 4'd0;
        end else begin
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, blanking, data enable and position, all registered on the tick edge.
// One-edge latency from tick to outputs; free running, no backpressure.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int H_FP           = DEF_H_FP,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BP           = DEF_H_BP,
    parameter int V_ACTIVE       = DEF_V_ACTIVE,
    parameter int V_FP           = DEF_V_FP,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BP           = DEF_V_BP,
    parameter int CE_DIV         = DEF_CE_DIV,
    parameter bit HS_ACTIVE_HIGH = 1'b0,
    parameter bit VS_ACTIVE_HIGH = 1'b0
) (
    input  logic             iPCLK,
    input  logic             iRSTn,
    output logic             oCE,
    output logic             oHS,
    output logic             oVS,
    output logic             oDE,
    output logic             oHBLANK,
    output logic             oVBLANK,
    output logic [CNT_W-1:0] oHCNT,
    output logic [CNT_W-1:0] oVCNT
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_total
            $error("video_timing_gen: timing totals exceed the 12-bit counter range");
        end
        if (CE_DIV < 1 || CE_DIV > 16) begin : g_bad_div
            $error("video_timing_gen: CE_DIV must be within 1..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic             tick;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             ce_q, ce_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             de_q, de_d;
    logic             hblank_q, hblank_d, vblank_q, vblank_d;

    video_ce_div #(
        .CE_DIV (CE_DIV)
    ) u_ce_div (
        .iPCLK (iPCLK),
        .iRSTn (iRSTn),
        .oTICK (tick)
    );

    // Outputs decode the next position so that counts and flags land on the same edge.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
            end else begin
                h_d = h_q + ONE;
            end
        end
        hcnt_d   = h_d;
        vcnt_d   = v_d;
        ce_d     = tick;
        hblank_d = (h_d >= H_ACT);
        vblank_d = (v_d >= V_ACT);
        de_d     = !hblank_d && !vblank_d;
        hs_d     = (h_d >= HS_FIRST && h_d <= HS_LAST) ? HS_ACTIVE_HIGH : !HS_ACTIVE_HIGH;
        vs_d     = (v_d >= VS_FIRST && v_d <= VS_LAST) ? VS_ACTIVE_HIGH : !VS_ACTIVE_HIGH;
    end

    // Position parks at the last pixel of the frame so the first tick lands on (0,0).
    always_ff @(posedge iPCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            h_q      <= H_LAST;
            v_q      <= V_LAST;
            ce_q     <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            de_q     <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hs_q     <= !HS_ACTIVE_HIGH;
            vs_q     <= !VS_ACTIVE_HIGH;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            ce_q <= ce_d;
            if (tick) begin
                hcnt_q   <= hcnt_d;
                vcnt_q   <= vcnt_d;
                de_q     <= de_d;
                hblank_q <= hblank_d;
                vblank_q <= vblank_d;
                hs_q     <= hs_d;
                vs_q     <= vs_d;
            end
        end
    end

    assign oCE     = ce_q;
    assign oHS     = hs_q;
    assign oVS     = vs_q;
    assign oDE     = de_q;
    assign oHBLANK = hblank_q;
    assign oVBLANK = vblank_q;
    assign oHCNT   = hcnt_q;
    assign oVCNT   = vcnt_q;

endmodule
